tex_index_clut_pipe: RTL
========================

// Module: tex_index_clut_pipe
// PURPOSE
//  Multi-lane texel decode + CLUT lookup pipeline for the GPU texture path. Per lane, takes a
//  16-bit VRAM texture word and U coordinate LSBs. Extracts the 4-bit or 8-bit palette index and
//  issues a CLUT read, or passes 16-bit direct colour through. Returns final 16-bit texel colours
//  in order through a valid/ready stream to the blend stage, absorbing backpressure internally.
// PARAMETERS
//  LANES     2  texels processed per beat (1 or 2; 2 = dual-pixel path)
//  CLUT_LAT  1  fixed read latency of CLUT cache in cycles (1 or 2)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous reset, active-high
//  i_valid      in   1          input beat valid
//  o_ready      out  1          input beat accepted when i_valid & o_ready
//  i_texFormat  in   2          0=4bpp, 1=8bpp, 2=16bpp, 3=reserved (handled as 16bpp)
//  i_data       in   16*LANES   texture word per lane (lane n = bits [16n+15:16n])
//  i_uLSB       in   2*LANES    U coordinate LSBs per lane
//  i_laneEn     in   LANES      lane enable mask
//  o_clutRd     out  1          CLUT read strobe (all lanes share it)
//  o_clutAddr   out  8*LANES    palette index per lane
//  i_clutData   in   16*LANES   CLUT colour, valid CLUT_LAT cycles after o_clutRd
//  o_valid      out  1          output beat valid
//  i_ready      in   1          downstream accepts when o_valid & i_ready
//  o_color      out  16*LANES   texel colour per lane
//  o_transp     out  LANES      lane colour == 16'h0000 (fully transparent texel)
//  o_laneEn     out  LANES      lane mask carried with the beat
// BEHAVIOUR
//  Reset: o_valid, o_clutRd, o_clutAddr, o_color, o_transp, o_laneEn = 0.
//   o_ready = 0 while rst is high. In-flight count = 0. Output FIFO empty.
//  Index extraction (combinational from inputs, per lane):
//   4bpp: nibble uLSB selects data[3:0],[7:4],[11:8],[15:12]; zero-extended to 8 bits.
//   8bpp: uLSB[0]=0 -> data[7:0], 1 -> data[15:8]; uLSB[1] ignored.
//   16bpp/reserved: no index; o_clutAddr = 0.
//  Accept cycle t: o_clutRd = accept & (fmt<=1). o_clutAddr driven in the same cycle.
//   A shift pipeline of CLUT_LAT stages carries valid, fmt, raw data and laneEn.
//  Cycle t+CLUT_LAT: colour = fmt<=1 ? i_clutData lane : raw data lane.
//   A disabled lane forces colour 0 and transp 0.
//   The beat {colour, transp, laneEn} is pushed into the output FIFO.
//  Output FIFO: DEPTH = CLUT_LAT+1 entries, registered outputs. o_valid is high while non-empty.
//   Minimum latency accept->o_valid is CLUT_LAT+1 cycles. Beats leave strictly in order.
//  Credit control: cnt counts accepted-but-not-popped beats (pipeline + FIFO), range 0..DEPTH.
//   o_ready = ~rst & ((cnt < DEPTH) | (o_valid & i_ready)). This is a combinational path from
//   i_ready, required for 1 beat/cycle at full occupancy.
//   Accept and pop in the same cycle leave cnt unchanged.
//   Because the CLUT read is never stalled, the FIFO can never overflow.
//  i_clutData is sampled only in pipeline slots that issued a read; it is ignored otherwise.
//  Format may change every beat. Each beat uses its own captured fmt.
//  Reset mid-operation: all in-flight beats and FIFO contents are discarded.
//   CLUT data returning after reset is ignored. No output beat appears until a new accept.
//  Output held stable (o_color/o_transp/o_laneEn) while o_valid & ~i_ready.
// TESTING
//  4bpp, LANES=2: lane0 data=A3C5 u=2, lane1 data=0F00 u=1 -> clutAddr={00,03}, clutRd=1.
//   CLUT returns lane0=7FFF, lane1=0000 -> color={0000,7FFF}, transp=2'b10.
//  8bpp: data=12AB, u=1 -> addr 12; u=2 -> addr AB; u=3 -> addr 12.
//  16bpp data=8000 and fmt=3 data=0000 -> clutRd=0, color 8000 transp 0, then color 0000 transp 1.
//  i_valid=1 and i_ready=0 for 10 cycles -> exactly CLUT_LAT+1 beats accepted, then o_ready=0.
//   Release -> all beats out in order, no loss or duplicate, then sustained 1 beat/cycle.
//  Assert rst with 2 beats in flight -> all outputs 0 next edge.
//   After release: o_ready=1 and o_valid=0 until a new beat has traversed the pipeline.
//  laneEn=2'b01, 4bpp -> lane1 color 0, transp 0, o_laneEn=01. Lane0 decoded normally.

Source files
------------

// File: rtl/tex_index_clut_pipe.sv
// Texel decode + CLUT lookup pipeline: extracts 4/8bpp palette indices or passes 16bpp colour,
// realigns CLUT returns with their beats and buffers results in a credit-controlled output FIFO.
module tex_index_clut_pipe #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned CLUT_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_texFormat,
    input  logic [16*LANES-1:0]   i_data,
    input  logic [2*LANES-1:0]    i_uLSB,
    input  logic [LANES-1:0]      i_laneEn,
    output logic                  o_clutRd,
    output logic [8*LANES-1:0]    o_clutAddr,
    input  logic [16*LANES-1:0]   i_clutData,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [16*LANES-1:0]   o_color,
    output logic [LANES-1:0]      o_transp,
    output logic [LANES-1:0]      o_laneEn
);

    localparam int unsigned DEPTH = CLUT_LAT + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned LAST  = CLUT_LAT - 1;

    logic          accept;
    logic          pop;
    logic          is_pal;
    logic [CW-1:0] cnt;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] fcnt_n;

    assign is_pal   = ~i_texFormat[1];
    assign pop      = o_valid & i_ready;
    assign o_ready  = ~rst & ((cnt < CW'(DEPTH)) | pop);
    assign accept   = i_valid & o_ready;
    assign o_clutRd = accept & is_pal;

    always_comb begin
        logic [15:0] word;
        logic [1:0]  u;
        logic [15:0] sh;
        word       = '0;
        u          = '0;
        sh         = '0;
        o_clutAddr = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            word = i_data[16*l +: 16];
            u    = i_uLSB[2*l +: 2];
            sh   = word >> {u, 2'b00};
            if (o_clutRd) begin
                o_clutAddr[8*l +: 8] = i_texFormat[0] ? (u[0] ? word[15:8] : word[7:0])
                                                      : {4'h0, sh[3:0]};
            end
        end
    end

    // Delay line matching the CLUT read latency; carries everything needed to finish the beat.
    logic [CLUT_LAT-1:0]                 p_vld;
    logic [CLUT_LAT-1:0]                 p_pal;
    logic [CLUT_LAT-1:0][16*LANES-1:0]   p_data;
    logic [CLUT_LAT-1:0][LANES-1:0]      p_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld  <= '0;
            p_pal  <= '0;
            p_data <= '0;
            p_en   <= '0;
        end else begin
            p_vld[0]  <= accept;
            p_pal[0]  <= is_pal;
            p_data[0] <= i_data;
            p_en[0]   <= i_laneEn;
            for (int s = 1; s < int'(CLUT_LAT); s++) begin
                p_vld[s]  <= p_vld[s-1];
                p_pal[s]  <= p_pal[s-1];
                p_data[s] <= p_data[s-1];
                p_en[s]   <= p_en[s-1];
            end
        end
    end

    logic                push;
    logic [16*LANES-1:0] new_col;
    logic [LANES-1:0]    new_tr;
    logic [LANES-1:0]    new_en;

    assign push = p_vld[LAST];

    always_comb begin
        new_en  = p_en[LAST];
        new_col = '0;
        new_tr  = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            if (new_en[l]) begin
                new_col[16*l +: 16] = p_pal[LAST] ? i_clutData[16*l +: 16]
                                                  : p_data[LAST][16*l +: 16];
                new_tr[l] = (new_col[16*l +: 16] == 16'h0000);
            end
        end
    end

    // Shift-down FIFO: entry 0 is the head and drives the outputs straight from flops.
    logic [DEPTH-1:0][16*LANES-1:0] f_col;
    logic [DEPTH-1:0][16*LANES-1:0] f_col_n;
    logic [DEPTH-1:0][LANES-1:0]    f_tr;
    logic [DEPTH-1:0][LANES-1:0]    f_tr_n;
    logic [DEPTH-1:0][LANES-1:0]    f_en;
    logic [DEPTH-1:0][LANES-1:0]    f_en_n;

    always_comb begin
        f_col_n = f_col;
        f_tr_n  = f_tr;
        f_en_n  = f_en;
        fcnt_n  = fcnt;
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                f_col_n[i] = f_col[i+1];
                f_tr_n[i]  = f_tr[i+1];
                f_en_n[i]  = f_en[i+1];
            end
            f_col_n[DEPTH-1] = '0;
            f_tr_n[DEPTH-1]  = '0;
            f_en_n[DEPTH-1]  = '0;
            fcnt_n = fcnt - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CW'(i) == fcnt_n) begin
                    f_col_n[i] = new_col;
                    f_tr_n[i]  = new_tr;
                    f_en_n[i]  = new_en;
                end
            end
            fcnt_n = fcnt_n + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_col <= '0;
            f_tr  <= '0;
            f_en  <= '0;
            fcnt  <= '0;
            cnt   <= '0;
        end else begin
            f_col <= f_col_n;
            f_tr  <= f_tr_n;
            f_en  <= f_en_n;
            fcnt  <= fcnt_n;
            if (accept && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (!accept && pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign o_valid  = (fcnt != '0);
    assign o_color  = f_col[0];
    assign o_transp = f_tr[0];
    assign o_laneEn = f_en[0];

endmodule
